// File: rtl/aes_roundtrip_ctrl.sv
// AES encipher->decipher round-trip sequencer: feeds one plaintext through both
// cores, compares the recovered text with the original and keeps statistics.
module aes_roundtrip_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     pt_in,
  input  logic             pt_valid,
  output logic             pt_ready,
  output logic             enc_start,
  output logic [127:0]     enc_block,
  input  logic             enc_done,
  input  logic [127:0]     enc_result,
  output logic             dec_start,
  output logic [127:0]     dec_block,
  input  logic             dec_done,
  input  logic [127:0]     dec_result,
  output logic [127:0]     cmp_a,
  output logic [127:0]     cmp_b,
  input  logic             cmp_equal,
  input  logic             clear_counts,
  output logic             busy,
  output logic             result_valid,
  output logic             last_match,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             timeout_flag
);

  typedef enum logic [2:0] {
    IDLE, ENC_ISSUE, ENC_WAIT, DEC_ISSUE, DEC_WAIT, COMPARE
  } state_t;

  // The abort fires on the edge at which the wait count would reach TIMEOUT-1,
  // so a hung core yields result_valid exactly TIMEOUT cycles after its start.
  localparam int WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TO_LAST_I);

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [127:0]        enc_block_reg, dec_block_reg, cmp_b_reg;
  logic                enc_start_reg, dec_start_reg;
  logic                result_valid_reg, last_match_reg, timeout_flag_reg;
  logic                timeout_hit;
  logic [1:0]          cnt_inc;

  always_comb begin
    timeout_hit = 1'b0;
    if (((state_reg == ENC_WAIT) && !enc_done) ||
        ((state_reg == DEC_WAIT) && !dec_done))
      timeout_hit = (wait_cnt_reg == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (pt_valid) state_next = ENC_ISSUE;
      ENC_ISSUE: state_next = ENC_WAIT;
      ENC_WAIT: begin
        if (enc_done)         state_next = DEC_ISSUE;
        else if (timeout_hit) state_next = IDLE;
      end
      DEC_ISSUE: state_next = DEC_WAIT;
      DEC_WAIT: begin
        if (dec_done)         state_next = COMPARE;
        else if (timeout_hit) state_next = IDLE;
      end
      COMPARE:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pt_ready = (state_reg == IDLE);
    busy     = (state_reg != IDLE);
  end

  // Start pulses are registered from the next-state decode so they line up with
  // the ISSUE states while coming straight out of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_start_reg    <= 1'b0;
      dec_start_reg    <= 1'b0;
      enc_block_reg    <= '0;
      dec_block_reg    <= '0;
      cmp_b_reg        <= '0;
      wait_cnt_reg     <= '0;
      result_valid_reg <= 1'b0;
      last_match_reg   <= 1'b0;
    end else begin
      enc_start_reg    <= (state_next == ENC_ISSUE);
      dec_start_reg    <= (state_next == DEC_ISSUE);
      result_valid_reg <= (state_reg == COMPARE) || timeout_hit;
      if ((state_reg == IDLE) && pt_valid)
        enc_block_reg <= pt_in;
      if ((state_reg == ENC_WAIT) && enc_done)
        dec_block_reg <= enc_result;
      if ((state_reg == DEC_WAIT) && dec_done)
        cmp_b_reg <= dec_result;
      if ((state_reg == ENC_ISSUE) || (state_reg == DEC_ISSUE))
        wait_cnt_reg <= '0;
      else if ((state_reg == ENC_WAIT) || (state_reg == DEC_WAIT))
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      if (state_reg == COMPARE)
        last_match_reg <= cmp_equal;
      else if (timeout_hit)
        last_match_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_counts) timeout_flag_reg <= 1'b0;
    else if (timeout_hit)    timeout_flag_reg <= 1'b1;
  end

  // Index 0 counts matches, index 1 counts mismatches and timeouts.
  assign cnt_inc[0] = (state_reg == COMPARE) && cmp_equal;
  assign cnt_inc[1] = ((state_reg == COMPARE) && !cmp_equal) || timeout_hit;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst || clear_counts)
        cnt_reg <= '0;
      else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign pass_count   = g_cnt[0].cnt_reg;
  assign fail_count   = g_cnt[1].cnt_reg;
  assign enc_start    = enc_start_reg;
  assign dec_start    = dec_start_reg;
  assign enc_block    = enc_block_reg;
  assign cmp_a        = enc_block_reg;
  assign dec_block    = dec_block_reg;
  assign cmp_b        = cmp_b_reg;
  assign result_valid = result_valid_reg;
  assign last_match   = last_match_reg;
  assign timeout_flag = timeout_flag_reg;

endmodule
